// File: rtl/risc8_bus_pkg.sv
// risc8_bus_pkg: transfer FSM encoding, register-bank defaults and internal bus width
package risc8_bus_pkg;
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_LATCH, S_DONE} state_t;
  localparam int NREG_DEF = 4;
  localparam int IDX_W_DEF = 2;
  localparam int BUS_W = 8;
endpackage

// File: rtl/bus_transfer_ctrl_if.sv
// bus_transfer_ctrl_if: requests (req, req_src, req_dst) in, grant/done/err/reg_en/reg_wr/busy out; master = control side, slave = controller
interface bus_transfer_ctrl_if import risc8_bus_pkg::*; #(
  parameter int NREQ = 4,
  parameter int NREG = NREG_DEF,
  parameter int IDX_W = IDX_W_DEF
) ();
  logic [NREQ-1:0]       req;
  logic [NREQ*IDX_W-1:0] req_src;
  logic [NREQ*IDX_W-1:0] req_dst;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  err;
  logic [NREG-1:0]       reg_en;
  logic [NREG-1:0]       reg_wr;
  logic                  busy;
  modport master (output req, req_src, req_dst, input grant, done, err, reg_en, reg_wr, busy);
  modport slave (input req, req_src, req_dst, output grant, done, err, reg_en, reg_wr, busy);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: i_req/i_ptr in, one-hot o_gnt and its index o_idx out; first requester at or above the pointer wins, wrapping
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_idx
);
  int k;
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    k = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = (int'(i_ptr) + i) % NREQ;
      if (i_req[k]) begin
        o_gnt = NREQ'(1) << k;
        o_idx = PW'(k);
      end
    end
  end
endmodule

// File: rtl/bus_transfer_ctrl.sv
// bus_transfer_ctrl: clk, async active-low reset, bif.slave bundle; round-robin sequencer of register-to-register moves with registered one-hot strobes
module bus_transfer_ctrl import risc8_bus_pkg::*; #(
  parameter int NREQ = 4,
  parameter int NREG = NREG_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input logic clk,
  input logic reset,
  bus_transfer_ctrl_if.slave bif
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  state_t r_state, w_state;
  logic [PW-1:0] r_ptr, w_ptr, w_idx;
  logic [NREQ-1:0] w_win, r_grant, w_grant, r_done, w_done;
  logic [IDX_W-1:0] r_src, r_dst, w_src, w_dst, w_nsrc, w_ndst;
  logic [NREG-1:0] r_en, w_en, r_wr, w_wr;
  logic r_err, w_err, r_busy;
  logic [2**IDX_W-1:0] w_ok;
  for (genvar g = 0; g < 2**IDX_W; g++) begin : g_ok
    assign w_ok[g] = g < NREG;
  end
  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (.i_req(bif.req), .i_ptr(r_ptr), .o_gnt(w_win), .o_idx(w_idx));
  assign w_nsrc = bif.req_src[w_idx*IDX_W +: IDX_W];
  assign w_ndst = bif.req_dst[w_idx*IDX_W +: IDX_W];
  // w_* carry the output values for the state being entered, so every output is a flop
  always_comb begin
    w_state = r_state;
    w_ptr = r_ptr;
    w_src = r_src;
    w_dst = r_dst;
    w_grant = r_grant;
    w_done = '0;
    w_err = 1'b0;
    w_en = '0;
    w_wr = '0;
    case (r_state)
      S_IDLE: if (|bif.req) begin
        w_src = w_nsrc;
        w_dst = w_ndst;
        w_grant = w_win;
        w_ptr = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
        if (w_ok[w_nsrc] && w_ok[w_ndst] && w_nsrc != w_ndst) begin
          w_state = S_DRIVE;
          w_en = NREG'(1) << w_nsrc;
        end else begin
          // trivial or invalid moves skip the bus entirely
          w_state = S_DONE;
          w_done = w_win;
          w_err = !(w_ok[w_nsrc] && w_ok[w_ndst]);
        end
      end
      S_DRIVE: begin
        w_state = S_LATCH;
        w_en = NREG'(1) << r_src;
        w_wr = NREG'(1) << r_dst;
      end
      S_LATCH: begin
        w_state = S_DONE;
        w_done = r_grant;
      end
      default: begin
        w_state = S_IDLE;
        w_grant = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ptr <= '0;
      r_src <= '0;
      r_dst <= '0;
      r_grant <= '0;
      r_done <= '0;
      r_err <= 1'b0;
      r_en <= '0;
      r_wr <= '0;
      r_busy <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ptr <= w_ptr;
      r_src <= w_src;
      r_dst <= w_dst;
      r_grant <= w_grant;
      r_done <= w_done;
      r_err <= w_err;
      r_en <= w_en;
      r_wr <= w_wr;
      r_busy <= w_state != S_IDLE;
    end
  end
  assign bif.grant = r_grant;
  assign bif.done = r_done;
  assign bif.err = r_err;
  assign bif.reg_en = r_en;
  assign bif.reg_wr = r_wr;
  assign bif.busy = r_busy;
endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// tb_bus_transfer_ctrl: directed and random moves checked every cycle against a transaction-level model and a bus-attached register bank
module tb_bus_transfer_ctrl;
  localparam int NREQ = 4;
  localparam int NREG = 3;
  localparam int IW = 2;
  typedef struct packed {
    logic [3:0] grant;
    logic [3:0] done;
    logic err;
    logic [2:0] en;
    logic [2:0] wr;
    logic busy;
  } outs_t;
  typedef struct {
    outs_t o;
    bit commit;
    int s;
    int d;
  } step_t;
  logic clk = 0;
  logic reset;
  int n_chk = 0;
  int n_fail = 0;
  step_t q[$];
  outs_t m_out = '0;
  int m_ptr = 0;
  logic [2:0][7:0] bank = {8'h33, 8'h22, 8'h11};
  logic [2:0][7:0] m_bank = {8'h33, 8'h22, 8'h11};
  logic [7:0] bus_val;
  bus_transfer_ctrl_if #(.NREQ(NREQ), .NREG(NREG), .IDX_W(IW)) bif ();
  bus_transfer_ctrl #(.NREQ(NREQ), .NREG(NREG), .IDX_W(IW)) u_dut (.clk(clk), .reset(reset), .bif(bif));
  always #5 clk = ~clk;
  always_comb begin
    bus_val = '0;
    for (int i = 0; i < NREG; i++) if (bif.reg_en[i]) bus_val = bus_val | bank[i];
  end
  always @(posedge clk) for (int i = 0; i < NREG; i++) if (bif.reg_wr[i]) bank[i] <= bus_val;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, want, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_rq(input int i, input int s, input int d);
    bif.req_src[i*IW +: IW] = IW'(s);
    bif.req_dst[i*IW +: IW] = IW'(d);
  endtask
  // Model: each accepted request expands into its list of per-cycle outputs
  initial begin
    int w, s, d;
    bit bad;
    step_t e;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        q.delete();
        m_ptr = 0;
        m_out = '0;
      end else begin
        if (q.size() == 0 && |bif.req) begin
          w = -1;
          for (int k = 0; k < NREQ; k++) if (w < 0 && bif.req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
          m_ptr = (w + 1) % NREQ;
          s = int'(bif.req_src[w*IW +: IW]);
          d = int'(bif.req_dst[w*IW +: IW]);
          bad = s >= NREG || d >= NREG;
          e.o = '0;
          e.commit = 0;
          e.s = s;
          e.d = d;
          e.o.grant = 4'(1 << w);
          e.o.busy = 1;
          if (bad || s == d) begin
            e.o.done = 4'(1 << w);
            e.o.err = bad;
            q.push_back(e);
          end else begin
            e.o.en = 3'(1 << s);
            q.push_back(e);
            e.o.wr = 3'(1 << d);
            q.push_back(e);
            e.o.en = 0;
            e.o.wr = 0;
            e.o.done = 4'(1 << w);
            e.commit = 1;
            q.push_back(e);
          end
          e.o = '0;
          e.commit = 0;
          q.push_back(e);
        end
        if (q.size() > 0) begin
          e = q.pop_front();
          m_out = e.o;
          if (e.commit) m_bank[e.d] = m_bank[e.s];
        end else m_out = '0;
      end
    end
  end
  always @(negedge clk) if (reset) begin
    check("outs", 64'({bif.grant, bif.done, bif.err, bif.reg_en, bif.reg_wr, bif.busy}), 64'(m_out));
    check("bank", 64'(bank), 64'(m_bank));
    check("strobe_inv", 64'({$onehot0(bif.reg_en), $onehot0(bif.reg_wr), !(|bif.reg_wr && !(|bif.reg_en))}), 64'(3'b111));
  end
  initial begin
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] prev;
    logic [7:0] old;
    reset = 0;
    bif.req = '0;
    bif.req_src = '0;
    bif.req_dst = '0;
    repeat (3) @(negedge clk);
    reset = 1;
    step();
    check("reset_outs", 64'({bif.grant, bif.done, bif.err, bif.reg_en, bif.reg_wr, bif.busy}), 0);
    repeat (20) step();
    check("idle_busy", 64'(bif.busy), 0);
    @(negedge clk);
    set_rq(0, 1, 2);
    bif.req = 4'b0001;
    step();
    check("t2_grant", 64'(bif.grant), 64'(4'b0001));
    check("t2_drive", 64'({bif.reg_en, bif.reg_wr}), 64'({3'b010, 3'b000}));
    step();
    check("t2_latch", 64'({bif.reg_en, bif.reg_wr}), 64'({3'b010, 3'b100}));
    step();
    check("t2_done", 64'({bif.done, bif.reg_en}), 64'({4'b0001, 3'b000}));
    check("t2_data", 64'(bank[2]), 64'(8'h22));
    @(negedge clk);
    bif.req = '0;
    step();
    check("t2_idle", 64'({bif.grant, bif.busy}), 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    reset = 1;
    set_rq(0, 0, 1);
    set_rq(1, 1, 2);
    set_rq(2, 2, 0);
    set_rq(3, 0, 2);
    bif.req = 4'b1111;
    prev = '0;
    repeat (20) begin
      step();
      if (bif.grant != 0 && prev == 0) for (int i = 0; i < NREQ; i++) if (bif.grant[i]) order.push_back(i);
      prev = bif.grant;
    end
    @(negedge clk);
    bif.req = '0;
    check("rr_count", 64'(order.size()), 5);
    for (int k = 0; k < order.size() && k < 5; k++) check("rr_order", 64'(order[k]), 64'(exp_order[k]));
    repeat (4) step();
    @(negedge clk);
    set_rq(2, 2, 2);
    bif.req = 4'b0100;
    step();
    check("t4_same", 64'({bif.grant, bif.done, bif.err, bif.reg_en, bif.reg_wr}), 64'({4'b0100, 4'b0100, 1'b0, 3'b0, 3'b0}));
    @(negedge clk);
    bif.req = '0;
    step();
    check("t4_same_idle", 64'({bif.done, bif.busy}), 0);
    @(negedge clk);
    set_rq(2, 1, 3);
    bif.req = 4'b0100;
    step();
    check("t4_invalid", 64'({bif.grant, bif.done, bif.err, bif.reg_en, bif.reg_wr}), 64'({4'b0100, 4'b0100, 1'b1, 3'b0, 3'b0}));
    @(negedge clk);
    bif.req = '0;
    step();
    check("t4_err_pulse", 64'(bif.err), 0);
    @(negedge clk);
    old = bank[1];
    set_rq(1, 0, 1);
    bif.req = 4'b0010;
    step();
    step();
    check("t5_latch", 64'(bif.reg_wr), 64'(3'b010));
    #1;
    reset = 0;
    #1;
    check("t5_abort", 64'({bif.grant, bif.done, bif.reg_en, bif.reg_wr, bif.busy}), 0);
    @(negedge clk);
    bif.req = '0;
    step();
    check("t5_no_write", 64'(bank[1]), 64'(old));
    check("t5_no_done", 64'(bif.done), 0);
    @(negedge clk);
    reset = 1;
    set_rq(3, 2, 0);
    bif.req = 4'b1010;
    step();
    check("t5_ptr_reset", 64'(bif.grant), 64'(4'b0010));
    step();
    step();
    @(negedge clk);
    bif.req = '0;
    step();
    @(negedge clk);
    set_rq(1, 2, 0);
    bif.req = 4'b0010;
    step();
    @(negedge clk);
    bif.req = '0;
    step();
    step();
    check("t6_done", 64'({bif.grant, bif.done}), 64'({4'b0010, 4'b0010}));
    step();
    repeat (2500) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (bif.done[i]) begin
          if ($urandom_range(1) == 0) bif.req[i] = 1'b0;
        end else if (bif.grant[i] && $urandom_range(15) == 0) bif.req[i] = 1'b0;
        else if (!bif.req[i] && $urandom_range(3) == 0) begin
          set_rq(i, int'($urandom_range(3)), int'($urandom_range(3)));
          bif.req[i] = 1'b1;
        end
      end
      if ($urandom_range(199) == 0) begin
        #2;
        reset = 0;
        @(posedge clk);
        #3;
        reset = 1;
      end
    end
    @(negedge clk);
    bif.req = '0;
    repeat (8) step();
    check("final_idle", 64'(bif.busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
